// File: rtl/dmem_responder.sv
// Big-endian byte-addressed data memory answering one word request at a time
// through valid/ready handshakes, after a fixed access latency.
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_err
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic [31:0]     resp_rdata_q;
    logic            resp_err_q;
    logic [7:0]      mem_q [DEPTH];

    logic            access_d;
    logic            aligned_d;
    logic            mem_we_d;
    logic [AW-1:0]   a0_d, a1_d, a2_d, a3_d;
    logic [31:0]     rd_word_d;

    // Byte lanes of the addressed word, MSB at the lowest address.
    always_comb begin
        a0_d      = {addr_q[AW-1:2], 2'b00};
        a1_d      = {addr_q[AW-1:2], 2'b01};
        a2_d      = {addr_q[AW-1:2], 2'b10};
        a3_d      = {addr_q[AW-1:2], 2'b11};
        aligned_d = (addr_q[1:0] == 2'b00);
        access_d  = (state_q == S_BUSY) && (cnt_q == CW'(0));
        mem_we_d  = access_d && we_q && aligned_d;
        rd_word_d = {mem_q[a0_d], mem_q[a1_d], mem_q[a2_d], mem_q[a3_d]};
    end

    // Memory array: not reset, written only at the BUSY->RESP edge of an aligned write.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[a0_d] <= wdata_q[31:24];
            mem_q[a1_d] <= wdata_q[23:16];
            mem_q[a2_d] <= wdata_q[15:8];
            mem_q[a3_d] <= wdata_q[7:0];
        end
    end

    // Request/latency/response control with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= CW'(0);
            we_q         <= 1'b0;
            addr_q       <= AW'(0);
            wdata_q      <= 32'h0000_0000;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        cnt_q       <= CW'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        state_q     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == CW'(0)) begin
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                        // Misaligned accesses and writes return zero data.
                        if (!aligned_d) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0000_0000;
                        end else if (we_q) begin
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= 32'h0000_0000;
                        end else begin
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= rd_word_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'h0000_0000;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    cnt_q        <= CW'(0);
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 32'h0000_0000;
                    resp_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (LATENCY 2, 3, 1)
// sharing stimulus, with one selected at a time; scoreboard holds expected responses.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;
    int          sel;

    logic [2:0]  rq_ready;
    logic [2:0]  rs_valid;
    logic [2:0]  rs_err;
    logic [31:0] rs_rdata [3];

    logic        cur_ready, cur_valid, cur_err;
    logic [31:0] cur_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;
    vec_t vt[10];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(32), .AW(5), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .req_valid(req_valid && (sel == 0)), .req_ready(rq_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rs_valid[0]),
        .resp_ready(resp_ready), .resp_rdata(rs_rdata[0]), .resp_err(rs_err[0]));

    dmem_responder #(.DEPTH(32), .AW(5), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .req_valid(req_valid && (sel == 1)), .req_ready(rq_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rs_valid[1]),
        .resp_ready(resp_ready), .resp_rdata(rs_rdata[1]), .resp_err(rs_err[1]));

    dmem_responder #(.DEPTH(32), .AW(5), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .req_valid(req_valid && (sel == 2)), .req_ready(rq_ready[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rs_valid[2]),
        .resp_ready(resp_ready), .resp_rdata(rs_rdata[2]), .resp_err(rs_err[2]));

    always_comb begin
        cur_ready = rq_ready[sel];
        cur_valid = rs_valid[sel];
        cur_err   = rs_err[sel];
        cur_rdata = rs_rdata[sel];
    end

    function automatic int lat_of(input int s);
        case (s)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (sel %0d): got %h expected %h", name, sel, act, exp);
        end
    endtask

    // One full transaction; optionally holds resp_ready low for bp cycles and
    // keeps a conflicting write to the same address on the request port while busy.
    task automatic run_txn(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                           input logic [31:0] er, input logic ee, input int bp, input bit intrude);
        exp_t e;
        int cyc;
        logic [31:0] held;
        e.rdata = er;
        e.err   = ee;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; resp_ready = 1'b0;
        cyc = 0;
        while (!cur_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_ready_idle", {31'd0, cur_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (intrude) begin
            req_we = 1'b1;
            req_wdata = 32'hFFFF_FFFF;
        end else begin
            req_valid = 1'b0;
        end
        cyc = 0;
        while (!cur_valid && cyc < 50) begin
            if (intrude) chk("req_ready_busy", {31'd0, cur_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        chk("latency", cyc, lat_of(sel));
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
        end
        chk("rdata", cur_rdata, e.rdata);
        chk("err", {31'd0, cur_err}, {31'd0, e.err});
        chk("req_ready_resp", {31'd0, cur_ready}, 32'd0);
        held = cur_rdata;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid", {31'd0, cur_valid}, 32'd1);
            chk("bp_rdata", cur_rdata, held);
            chk("bp_ready", {31'd0, cur_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_valid", {31'd0, cur_valid}, 32'd0);
        chk("post_ready", {31'd0, cur_ready}, 32'd1);
        chk("post_rdata", cur_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{1'b1, 5'h08, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vt[1] = '{1'b0, 5'h08, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vt[2] = '{1'b1, 5'h1C, 32'h0123_4567, 32'h0000_0000, 1'b0};
        vt[3] = '{1'b0, 5'h1C, 32'h0000_0000, 32'h0123_4567, 1'b0};
        vt[4] = '{1'b0, 5'h10, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vt[5] = '{1'b1, 5'h04, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vt[6] = '{1'b1, 5'h05, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vt[7] = '{1'b0, 5'h04, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vt[8] = '{1'b0, 5'h06, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vt[9] = '{1'b1, 5'h1F, 32'h1111_1111, 32'h0000_0000, 1'b1};

        sel = 0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 5'h00;
        req_wdata = 32'h0; resp_ready = 1'b0;
        #12;
        chk("rst_ready", {31'd0, cur_ready}, 32'd1);
        chk("rst_valid", {31'd0, cur_valid}, 32'd0);
        chk("rst_rdata", cur_rdata, 32'd0);
        chk("rst_err", {31'd0, cur_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].err, 0, 1'b0);

        chk("byte8", {24'd0, u_l2.mem_q[8]}, 32'h0000_00DE);
        chk("byte9", {24'd0, u_l2.mem_q[9]}, 32'h0000_00AD);
        chk("byte10", {24'd0, u_l2.mem_q[10]}, 32'h0000_00BE);
        chk("byte11", {24'd0, u_l2.mem_q[11]}, 32'h0000_00EF);

        run_txn(1'b0, 5'h08, 32'h0, 32'hDEAD_BEEF, 1'b0, 5, 1'b0);
        run_txn(1'b0, 5'h1C, 32'h0, 32'h0123_4567, 1'b0, 0, 1'b1);
        run_txn(1'b0, 5'h1C, 32'h0, 32'h0123_4567, 1'b0, 0, 1'b0);

        // Reset one cycle into a LATENCY=3 write must leave memory untouched.
        sel = 1;
        run_txn(1'b1, 5'h00, 32'h1122_3344, 32'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5'h00; req_wdata = 32'h55AA_55AA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_before_reset", {31'd0, cur_ready}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, cur_ready}, 32'd1);
        chk("midrst_valid", {31'd0, cur_valid}, 32'd0);
        chk("midrst_rdata", cur_rdata, 32'd0);
        chk("midrst_err", {31'd0, cur_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_txn(1'b0, 5'h00, 32'h0, 32'h1122_3344, 1'b0, 0, 1'b0);
        run_txn(1'b0, 5'h02, 32'h0, 32'h0, 1'b1, 2, 1'b0);

        sel = 2;
        run_txn(1'b1, 5'h0C, 32'hA5A5_A5A5, 32'h0, 1'b0, 0, 1'b0);
        run_txn(1'b0, 5'h0C, 32'h0, 32'hA5A5_A5A5, 1'b0, 0, 1'b1);
        run_txn(1'b0, 5'h0C, 32'h0, 32'hA5A5_A5A5, 1'b0, 1, 1'b0);
        run_txn(1'b0, 5'h14, 32'h0, 32'h0, 1'b0, 0, 1'b0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
